midi_voice_allocator: RTL and testbench
=======================================

MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk_in and rst_in.
REQ-002 Parameter CHANNEL, default 4'd0, SHALL be the MIDI channel accepted.
REQ-003 Parameter FIRST_SLOT, default 1, SHALL be the lowest slot index ever allocated.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 midi_byte_in  input  8  received MIDI byte.
REQ-007 midi_byte_valid_in  input  1  single-cycle strobe; midi_byte_in is valid this cycle.
REQ-008 midi_burst_data_out  output  16 x [4:0]  per slot: {note[15:8], velocity[7:0]}.
REQ-009 on_array_out  output  5  per-slot occupied flag.
REQ-010 midi_burst_change_out  output  1  single-cycle pulse when slot table changed.
REQ-011 voice_count_out  output  3  number of occupied slots.
REQ-012 dropped_out  output  1  single-cycle pulse when a note-on found no free slot.

Function
REQ-013 The parser SHALL have states WAIT_STATUS, WAIT_D1, WAIT_D2 and SHALL advance only on cycles with midi_byte_valid_in=1.
REQ-014 Bytes 0xF8-0xFF SHALL be ignored without changing parser state or running status.
REQ-015 Bytes 0xF0-0xF7 SHALL clear running status and return the parser to WAIT_STATUS.
REQ-016 Bytes 0x80-0xEF SHALL load running status and move to WAIT_D1; 0xCn/0xDn expect one data byte, all others two.
REQ-017 A data byte (bit7=0) in WAIT_STATUS SHALL be ignored if running status is clear; otherwise it SHALL be taken as D1 (running status).
REQ-018 After the final data byte the parser SHALL return to WAIT_D1 (running status kept), and the message SHALL be acted on only if its channel equals CHANNEL.
REQ-019 Messages acted on: 0x9n with vel!=0 = note-on; 0x8n, or 0x9n with vel=0 = note-off; 0xBn 0x7B xx = all-notes-off; all others are discarded.
REQ-020 Note-on for a note already held SHALL overwrite that slot's velocity only; no new slot SHALL be allocated.
REQ-021 Note-on for a new note SHALL take the lowest free slot index >= FIRST_SLOT; slots below FIRST_SLOT SHALL stay zero and off.
REQ-022 Note-on with no free slot SHALL leave the table unchanged, pulse dropped_out, and SHALL NOT pulse midi_burst_change_out.
REQ-023 Note-off SHALL clear the matching slot (on=0, data=16'h0000); if no slot matches, there SHALL be no change and no pulse.
REQ-024 All-notes-off SHALL clear every slot; it SHALL pulse change only if at least one slot was on.
REQ-025 Table outputs, voice_count_out and the change/dropped pulses SHALL update on the clock edge following the cycle that carries the final message byte (1-cycle latency), all in the same cycle.
REQ-026 Between change pulses, midi_burst_data_out, on_array_out and voice_count_out SHALL be held stable.
REQ-027 voice_count_out SHALL always equal popcount(on_array_out).

Reset
REQ-028 On rst_in, all slots, on_array_out, voice_count_out, midi_burst_change_out and dropped_out SHALL be 0; the parser SHALL be in WAIT_STATUS with running status cleared.
REQ-029 A reset asserted mid-message SHALL discard the partial message; no pulse SHALL follow.

Structure
REQ-030 Package midi_pkg SHALL hold status-nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB), CC_ALL_NOTES_OFF=7'h7B, NUM_SLOTS=5 and the parsed-message struct typedef {kind, note, velocity}.
REQ-031 Byte parsing SHALL be a sub-module midi_byte_parser emitting a one-cycle msg_valid with the parsed-message struct; allocation logic SHALL stay in the top module.

Verification
REQ-032 Bytes 90 3C 64 -> one cycle later slot1=16'h3C64, on=5'b00010, count=1, one change pulse.
REQ-033 Then 40 50 (running status) -> slot2=16'h4050, on=5'b00110; then 3C 00 -> slot1 cleared, on=5'b00100.
REQ-034 Four distinct note-ons fill slots 1-4; fifth note-on 90 48 7F -> dropped_out pulse, no change pulse, table unchanged.
REQ-035 90 3C, F8, 64 -> F8 ignored, slot1=16'h3C64; 91 3C 64 (channel 1) -> no change.
REQ-036 Slots 1-3 on, then B0 7B 00 -> all slots 0, count=0, one change pulse; repeat -> no pulse.
REQ-037 90 3C then rst_in for 1 cycle, then 64 -> no table change, no pulse.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared constants and message types for the MIDI voice allocator.
// The parser and allocator both import this package.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF      = 4'h8;
   localparam logic [3:0] NOTE_ON       = 4'h9;
   localparam logic [3:0] CC            = 4'hB;
   localparam logic [3:0] PROG_CHANGE   = 4'hC;
   localparam logic [3:0] CHAN_PRESSURE = 4'hD;

   localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'h7B;
   localparam int unsigned NUM_SLOTS        = 5;

   typedef enum logic [1:0] {
      MsgNone,
      MsgNoteOn,
      MsgNoteOff,
      MsgAllOff
   } msg_kind_e;

   typedef struct packed {
      msg_kind_e  kind;
      logic [6:0] note;
      logic [6:0] velocity;
   } midi_msg_t;

   function automatic logic [2:0] popcount_slots(input logic [NUM_SLOTS-1:0] v);
      logic [2:0] c;
      c = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         c = c + {2'b00, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Byte input and slot-table outputs of the MIDI voice allocator.
// master drives bytes and observes the table; slave is the allocator itself.
interface midi_voice_allocator_if;

   logic [7:0]                              midi_byte_in;
   logic                                    midi_byte_valid_in;
   logic [midi_pkg::NUM_SLOTS-1:0][15:0]    midi_burst_data_out;
   logic [midi_pkg::NUM_SLOTS-1:0]          on_array_out;
   logic                                    midi_burst_change_out;
   logic [2:0]                              voice_count_out;
   logic                                    dropped_out;

   modport master (
      output midi_byte_in,
      output midi_byte_valid_in,
      input  midi_burst_data_out,
      input  on_array_out,
      input  midi_burst_change_out,
      input  voice_count_out,
      input  dropped_out
   );

   modport slave (
      input  midi_byte_in,
      input  midi_byte_valid_in,
      output midi_burst_data_out,
      output on_array_out,
      output midi_burst_change_out,
      output voice_count_out,
      output dropped_out
   );

endinterface

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with running status; emits a one-cycle msg_valid_out,
// combinationally, in the cycle carrying the final byte of a relevant message.
module midi_byte_parser
   import midi_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output logic       msg_valid_out,
   output midi_msg_t  msg_out
);

   typedef enum logic [1:0] {
      StWaitStatus,
      StWaitD1,
      StWaitD2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] status_q, status_d;
   logic [6:0] d1_q, d1_d;
   logic       complete;
   logic       one_byte;
   logic [6:0] d1_final, d2_final;

   assign one_byte = (status_q[7:4] == PROG_CHANGE) || (status_q[7:4] == CHAN_PRESSURE);

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      d1_d     = d1_q;
      complete = 1'b0;
      d1_final = d1_q;
      d2_final = '0;
      if (byte_valid_in) begin
         if (byte_in[7:4] == 4'hF) begin
            // Real-time bytes (F8-FF) pass through without touching anything.
            if (!byte_in[3]) begin
               status_d = '0;
               state_d  = StWaitStatus;
            end
         end else if (byte_in[7]) begin
            status_d = byte_in;
            state_d  = StWaitD1;
         end else if (state_q == StWaitD2) begin
            complete = 1'b1;
            d2_final = byte_in[6:0];
            state_d  = StWaitD1;
         end else if ((state_q == StWaitD1) || status_q[7]) begin
            if (one_byte) begin
               complete = 1'b1;
               d1_final = byte_in[6:0];
               state_d  = StWaitD1;
            end else begin
               d1_d    = byte_in[6:0];
               state_d = StWaitD2;
            end
         end
      end
   end

   always_comb begin
      msg_out.kind     = MsgNone;
      msg_out.note     = d1_final;
      msg_out.velocity = d2_final;
      if (complete && (status_q[3:0] == CHANNEL)) begin
         case (status_q[7:4])
            NOTE_ON:  msg_out.kind = (d2_final != 7'd0) ? MsgNoteOn : MsgNoteOff;
            NOTE_OFF: msg_out.kind = MsgNoteOff;
            CC: begin
               if (d1_final == CC_ALL_NOTES_OFF) msg_out.kind = MsgAllOff;
            end
            default: msg_out.kind = MsgNone;
         endcase
      end
      msg_valid_out = (msg_out.kind != MsgNone);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= StWaitStatus;
         status_q <= '0;
         d1_q     <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         d1_q     <= d1_d;
      end
   end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off messages onto a small slot table
// and reports table changes and dropped notes one cycle after the final byte.
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter logic [3:0]  CHANNEL    = 4'd0,
   parameter int unsigned FIRST_SLOT = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   midi_voice_allocator_if.slave  bus_if
);

   logic      msg_valid;
   midi_msg_t msg;

   logic [NUM_SLOTS-1:0][15:0] data_q, data_d;
   logic [NUM_SLOTS-1:0]       on_q, on_d;
   logic [NUM_SLOTS-1:0]       hit_oh, free_oh;
   logic                       free_found;
   logic                       change_q, change_d;
   logic                       dropped_q, dropped_d;
   logic [2:0]                 count_q, count_d;

   midi_byte_parser #(
      .CHANNEL (CHANNEL)
   ) u_parser (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .byte_in       (bus_if.midi_byte_in),
      .byte_valid_in (bus_if.midi_byte_valid_in),
      .msg_valid_out (msg_valid),
      .msg_out       (msg)
   );

   // Slots below FIRST_SLOT are never matched nor allocated, so they stay zero.
   always_comb begin
      hit_oh     = '0;
      free_oh    = '0;
      free_found = 1'b0;
      for (int unsigned i = FIRST_SLOT; i < NUM_SLOTS; i++) begin
         hit_oh[i] = on_q[i] && (data_q[i][15:8] == {1'b0, msg.note});
         if (!on_q[i] && !free_found) begin
            free_oh[i] = 1'b1;
            free_found = 1'b1;
         end
      end
   end

   always_comb begin
      data_d    = data_q;
      on_d      = on_q;
      change_d  = 1'b0;
      dropped_d = 1'b0;
      if (msg_valid) begin
         case (msg.kind)
            MsgNoteOn: begin
               if (|hit_oh) begin
                  for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                     if (hit_oh[i] && (data_q[i][7:0] != {1'b0, msg.velocity})) begin
                        data_d[i][7:0] = {1'b0, msg.velocity};
                        change_d       = 1'b1;
                     end
                  end
               end else if (free_found) begin
                  for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                     if (free_oh[i]) begin
                        on_d[i]   = 1'b1;
                        data_d[i] = {1'b0, msg.note, 1'b0, msg.velocity};
                     end
                  end
                  change_d = 1'b1;
               end else begin
                  dropped_d = 1'b1;
               end
            end
            MsgNoteOff: begin
               for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                  if (hit_oh[i]) begin
                     on_d[i]   = 1'b0;
                     data_d[i] = '0;
                  end
               end
               change_d = |hit_oh;
            end
            MsgAllOff: begin
               on_d     = '0;
               data_d   = '0;
               change_d = |on_q;
            end
            default: ;
         endcase
      end
      count_d = popcount_slots(on_d);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         data_q    <= '0;
         on_q      <= '0;
         change_q  <= 1'b0;
         dropped_q <= 1'b0;
         count_q   <= '0;
      end else begin
         data_q    <= data_d;
         on_q      <= on_d;
         change_q  <= change_d;
         dropped_q <= dropped_d;
         count_q   <= count_d;
      end
   end

   assign bus_if.midi_burst_data_out   = data_q;
   assign bus_if.on_array_out          = on_q;
   assign bus_if.midi_burst_change_out = change_q;
   assign bus_if.voice_count_out       = count_q;
   assign bus_if.dropped_out           = dropped_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: directed vector table, reset-mid-message
// sequence, then random byte streams against a queue-based reference model.
module tb_midi_voice_allocator;
   import midi_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   midi_voice_allocator_if bus_if ();

   midi_voice_allocator #(
      .CHANNEL    (4'd0),
      .FIRST_SLOT (1)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus_if (bus_if)
   );

   typedef struct {
      logic [7:0]  b;
      logic [4:0]  on;
      logic [2:0]  cnt;
      logic        chg;
      logic        drp;
      logic [79:0] data;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: slot table plus running status and pending data bytes.
   logic [7:0] m_note[NUM_SLOTS];
   logic [7:0] m_vel[NUM_SLOTS];
   bit         m_on[NUM_SLOTS];
   logic [7:0] m_rs;
   logic [7:0] m_pend[$];

   function automatic logic [79:0] mk(input logic [15:0] s1, input logic [15:0] s2,
                                      input logic [15:0] s3, input logic [15:0] s4);
      return {s4, s3, s2, s1, 16'h0000};
   endfunction

   function automatic void add(input logic [7:0] b, input logic [4:0] on, input logic [2:0] cnt,
                               input logic chg, input logic drp, input logic [79:0] data);
      vec_t v;
      v.b = b; v.on = on; v.cnt = cnt; v.chg = chg; v.drp = drp; v.data = data;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [4:0] on, input logic [2:0] cnt,
                            input logic chg, input logic drp, input logic [79:0] data);
      check({tag, "_on"}, 80'(bus_if.on_array_out), 80'(on));
      check({tag, "_cnt"}, 80'(bus_if.voice_count_out), 80'(cnt));
      check({tag, "_chg"}, 80'(bus_if.midi_burst_change_out), 80'(chg));
      check({tag, "_drp"}, 80'(bus_if.dropped_out), 80'(drp));
      check({tag, "_data"}, bus_if.midi_burst_data_out, data);
   endtask

   // Called at posedge+1; returns at posedge+1 after the edge that sampled the byte.
   task automatic send_byte(input logic [7:0] b);
      bus_if.midi_byte_in       = b;
      bus_if.midi_byte_valid_in = 1'b1;
      @(posedge clk);
      #1;
      bus_if.midi_byte_valid_in = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_on[i] = 1'b0; m_note[i] = '0; m_vel[i] = '0;
      end
      m_rs = '0;
      m_pend.delete();
   endfunction

   function automatic void model_msg(input logic [7:0] st, input logic [7:0] d1,
                                     input logic [7:0] d2, output bit chg, output bit drp);
      int slot;
      chg = 0; drp = 0;
      if (st[3:0] != 4'd0) return;
      slot = -1;
      for (int i = 1; i < NUM_SLOTS; i++) if (m_on[i] && m_note[i] == d1) slot = i;
      if (st[7:4] == 4'h9 && d2 != 0) begin
         if (slot >= 0) begin
            if (m_vel[slot] != d2) begin m_vel[slot] = d2; chg = 1; end
         end else begin
            for (int i = 1; i < NUM_SLOTS && slot < 0; i++) if (!m_on[i]) slot = i;
            if (slot >= 0) begin
               m_on[slot] = 1; m_note[slot] = d1; m_vel[slot] = d2; chg = 1;
            end else drp = 1;
         end
      end else if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
         if (slot >= 0) begin
            m_on[slot] = 0; m_note[slot] = '0; m_vel[slot] = '0; chg = 1;
         end
      end else if (st[7:4] == 4'hB && d1 == 8'h7B) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_on[i]) chg = 1;
            m_on[i] = 0; m_note[i] = '0; m_vel[i] = '0;
         end
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b, output bit chg, output bit drp);
      int need;
      chg = 0; drp = 0;
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin m_rs = '0; m_pend.delete(); return; end
      if (b[7]) begin m_rs = b; m_pend.delete(); return; end
      if (m_rs == 8'h00) return;
      m_pend.push_back(b);
      need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
      if (m_pend.size() == need) begin
         model_msg(m_rs, m_pend[0], (need == 2) ? m_pend[1] : 8'h00, chg, drp);
         m_pend.delete();
      end
   endfunction

   function automatic logic [79:0] model_data();
      logic [79:0] d;
      d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) if (m_on[i]) d[i*16 +: 16] = {m_note[i], m_vel[i]};
      return d;
   endfunction

   function automatic logic [4:0] model_on();
      logic [4:0] o;
      for (int i = 0; i < NUM_SLOTS; i++) o[i] = m_on[i];
      return o;
   endfunction

   function automatic logic [2:0] model_cnt();
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < NUM_SLOTS; i++) if (m_on[i]) c = c + 3'd1;
      return c;
   endfunction

   initial begin
      logic [79:0] z, f, g, h;
      logic [7:0]  rb;
      bit          ec, ed;
      logic [7:0]  statuses[8];

      bus_if.midi_byte_in       = 8'h00;
      bus_if.midi_byte_valid_in = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      check_all("reset", 5'b0, 3'd0, 1'b0, 1'b0, '0);

      z = '0;
      f = mk(16'h3C11, 16'h4050, 16'h4522, 16'h4633);
      g = mk(16'h3C55, 16'h4050, 16'h4522, 16'h4633);
      h = mk(16'h3C64, 16'h0000, 16'h0000, 16'h0000);
      add(8'h90, 5'b00000, 3'd0, 0, 0, z);
      add(8'h3C, 5'b00000, 3'd0, 0, 0, z);
      add(8'h64, 5'b00010, 3'd1, 1, 0, h);
      add(8'h40, 5'b00010, 3'd1, 0, 0, h);
      add(8'h50, 5'b00110, 3'd2, 1, 0, mk(16'h3C64, 16'h4050, 0, 0));
      add(8'h3C, 5'b00110, 3'd2, 0, 0, mk(16'h3C64, 16'h4050, 0, 0));
      add(8'h00, 5'b00100, 3'd1, 1, 0, mk(0, 16'h4050, 0, 0));
      add(8'h90, 5'b00100, 3'd1, 0, 0, mk(0, 16'h4050, 0, 0));
      add(8'h3C, 5'b00100, 3'd1, 0, 0, mk(0, 16'h4050, 0, 0));
      add(8'h11, 5'b00110, 3'd2, 1, 0, mk(16'h3C11, 16'h4050, 0, 0));
      add(8'h45, 5'b00110, 3'd2, 0, 0, mk(16'h3C11, 16'h4050, 0, 0));
      add(8'h22, 5'b01110, 3'd3, 1, 0, mk(16'h3C11, 16'h4050, 16'h4522, 0));
      add(8'h46, 5'b01110, 3'd3, 0, 0, mk(16'h3C11, 16'h4050, 16'h4522, 0));
      add(8'h33, 5'b11110, 3'd4, 1, 0, f);
      add(8'h90, 5'b11110, 3'd4, 0, 0, f);
      add(8'h48, 5'b11110, 3'd4, 0, 0, f);
      add(8'h7F, 5'b11110, 3'd4, 0, 1, f);
      add(8'h3C, 5'b11110, 3'd4, 0, 0, f);
      add(8'h55, 5'b11110, 3'd4, 1, 0, g);
      add(8'hB0, 5'b11110, 3'd4, 0, 0, g);
      add(8'h7B, 5'b11110, 3'd4, 0, 0, g);
      add(8'h00, 5'b00000, 3'd0, 1, 0, z);
      add(8'hB0, 5'b00000, 3'd0, 0, 0, z);
      add(8'h7B, 5'b00000, 3'd0, 0, 0, z);
      add(8'h00, 5'b00000, 3'd0, 0, 0, z);
      add(8'h90, 5'b00000, 3'd0, 0, 0, z);
      add(8'h3C, 5'b00000, 3'd0, 0, 0, z);
      add(8'hF8, 5'b00000, 3'd0, 0, 0, z);
      add(8'h64, 5'b00010, 3'd1, 1, 0, h);
      add(8'h91, 5'b00010, 3'd1, 0, 0, h);
      add(8'h3C, 5'b00010, 3'd1, 0, 0, h);
      add(8'h64, 5'b00010, 3'd1, 0, 0, h);
      add(8'h80, 5'b00010, 3'd1, 0, 0, h);
      add(8'h3C, 5'b00010, 3'd1, 0, 0, h);
      add(8'h40, 5'b00000, 3'd0, 1, 0, z);
      add(8'h3C, 5'b00000, 3'd0, 0, 0, z);
      add(8'h40, 5'b00000, 3'd0, 0, 0, z);
      add(8'h90, 5'b00000, 3'd0, 0, 0, z);
      add(8'h3C, 5'b00000, 3'd0, 0, 0, z);
      add(8'hF0, 5'b00000, 3'd0, 0, 0, z);
      add(8'h64, 5'b00000, 3'd0, 0, 0, z);
      add(8'h3C, 5'b00000, 3'd0, 0, 0, z);
      add(8'h64, 5'b00000, 3'd0, 0, 0, z);

      foreach (vecs[i]) begin
         send_byte(vecs[i].b);
         check_all($sformatf("vec%0d", i), vecs[i].on, vecs[i].cnt, vecs[i].chg, vecs[i].drp,
                   vecs[i].data);
      end

      // Change pulse lasts exactly one cycle and the table holds afterwards.
      send_byte(8'h90); send_byte(8'h40); send_byte(8'h50);
      check_all("pulse_hi", 5'b00010, 3'd1, 1, 0, mk(16'h4050, 0, 0, 0));
      idle_cycle();
      check_all("pulse_lo", 5'b00010, 3'd1, 0, 0, mk(16'h4050, 0, 0, 0));

      // Reset in the middle of a message discards it.
      send_byte(8'h90); send_byte(8'h3C);
      do_reset();
      check_all("midrst", 5'b0, 3'd0, 0, 0, z);
      send_byte(8'h64);
      check_all("midrst_d2", 5'b0, 3'd0, 0, 0, z);
      idle_cycle();
      check_all("midrst_idle", 5'b0, 3'd0, 0, 0, z);

      // Random byte streams against the reference model.
      model_reset();
      statuses = '{8'h80, 8'h90, 8'h90, 8'hB0, 8'h91, 8'hC0, 8'hD0, 8'hE0};
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 12) rb = statuses[$urandom_range(0, 7)];
         else if (r < 14) rb = 8'hF8 + 8'($urandom_range(0, 7));
         else if (r < 15) rb = 8'hF0 + 8'($urandom_range(0, 7));
         else if (r < 65) rb = 8'h3C + 8'($urandom_range(0, 6));
         else if (r < 72) rb = 8'h7B;
         else if (r < 80) rb = 8'h00;
         else rb = 8'($urandom_range(0, 127));
         send_byte(rb);
         model_byte(rb, ec, ed);
         check_all($sformatf("rnd%0d_%h", n, rb), model_on(), model_cnt(), ec, ed, model_data());
         if ($urandom_range(0, 9) == 0) begin
            idle_cycle();
            check_all($sformatf("rnd%0d_idle", n), model_on(), model_cnt(), 0, 0, model_data());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
